// File: rtl/softmax_result_serializer.sv
// softmax_result_serializer
// Read side of the softermax pipeline's parallel result vector. A launch sends a tag down a
// PIPE_LAT-stage delay line. When the tag reaches the last stage, res_vec_in is captured into a
// buffer. The buffered elements are then streamed out one per beat over valid/ready.
// launch_ready is a launch credit: it is high only while nothing is in flight or buffered.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   launch_valid/_ready  upstream launch handshake
//   res_vec_in       VEC_SIZE x RES_BW parallel result vector from the pipeline
//   out_valid/_ready downstream beat handshake
//   out_data/_idx/_last  element data, element index, final-beat flag
//   busy             launch in flight or buffer non-empty
//
// Optional feature: define SOFTMAX_SER_CHECKSUM_EN to append a checksum beat
// (out_idx = VEC_SIZE, data = modulo-2^RES_BW sum of the captured elements).
module softmax_result_serializer #(
    parameter int VEC_SIZE = 10,
    parameter int RES_BW   = 32,
    parameter int PIPE_LAT = 3,
    parameter int IDX_BW   = $clog2(VEC_SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch_valid,
    output logic              launch_ready,
    input  logic [RES_BW-1:0] res_vec_in [VEC_SIZE],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_BW-1:0] out_data,
    output logic [IDX_BW-1:0] out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

`ifdef SOFTMAX_SER_CHECKSUM_EN
    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(VEC_SIZE);
`else
    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(VEC_SIZE - 1);
`endif

    logic [1:0]          r_state;
    logic [PIPE_LAT-1:0] r_tag;
    logic [RES_BW-1:0]   r_buf [VEC_SIZE];
    logic [IDX_BW-1:0]   r_idx;

    logic                w_accept;
    logic                w_capture;
    logic [RES_BW-1:0]   w_elem;

    assign w_accept  = launch_valid && (r_state == ST_IDLE);
    // Only one tag can be in flight, so the emerging stage alone marks the capture edge.
    assign w_capture = r_tag[PIPE_LAT-1];

`ifdef SOFTMAX_SER_CHECKSUM_EN
    logic [RES_BW-1:0] r_sum;
    logic [RES_BW-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            w_sum = w_sum + res_vec_in[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tag   <= '0;
            r_idx   <= '0;
            for (int i = 0; i < VEC_SIZE; i++) begin
                r_buf[i] <= '0;
            end
`ifdef SOFTMAX_SER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_tag[0] <= w_accept;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        for (int i = 0; i < VEC_SIZE; i++) begin
                            r_buf[i] <= res_vec_in[i];
                        end
`ifdef SOFTMAX_SER_CHECKSUM_EN
                        r_sum   <= w_sum;
`endif
                        r_idx   <= '0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Element select by comparison so the checksum index never addresses past the buffer.
    always_comb begin
        w_elem = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (r_idx == IDX_BW'(i)) begin
                w_elem = r_buf[i];
            end
        end
`ifdef SOFTMAX_SER_CHECKSUM_EN
        if (r_idx == LAST_IDX) begin
            w_elem = r_sum;
        end
`endif
    end

    assign out_valid    = (r_state == ST_DRAIN);
    assign out_data     = out_valid ? w_elem : '0;
    assign out_idx      = r_idx;
    assign out_last     = out_valid && (r_idx == LAST_IDX);
    assign launch_ready = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);

endmodule
